// File: rtl/score_display_ctrl_pkg.sv
// Shared video definitions for the score display path: glyph geometry,
// the blank digit code, the BCD digit type and the adder state encoding.
package video_pkg;
  localparam int         GLYPH_W     = 16;
  localparam int         GLYPH_H     = 10;
  localparam logic [3:0] BLANK_DIGIT = 4'hF;

  typedef logic [3:0] bcd_t;

  typedef enum logic {S_IDLE, S_ADD} add_state_e;

  // Clamp an add amount to a legal BCD digit.
  function automatic bcd_t bcd_sat(input logic [3:0] v);
    return (v > 4'd9) ? 4'd9 : v;
  endfunction
endpackage

// File: rtl/score_display_ctrl_if.sv
// Score update port: add request handshake plus the clear strobe.
interface score_display_ctrl_if;
  import video_pkg::*;
  logic add_valid;
  bcd_t add_value;
  logic add_ready;
  logic clr;

  modport master (output add_valid, add_value, clr, input add_ready);
  modport slave  (input add_valid, add_value, clr, output add_ready);
endinterface

// File: rtl/score_display_ctrl_bcd_digit_add.sv
// Single BCD digit adder; the second operand may be a full digit so the
// first step of an add can inject the whole amount as the carry.
module bcd_digit_add
  import video_pkg::*;
(
  input  bcd_t       i_a,
  input  logic [3:0] i_b,
  output bcd_t       o_sum,
  output logic       o_carry
);
  logic [4:0] w_s;
  assign w_s     = {1'b0, i_a} + {1'b0, i_b};
  assign o_carry = (w_s >= 5'd10);
  assign o_sum   = o_carry ? 4'(w_s - 5'd10) : w_s[3:0];
endmodule

// File: rtl/score_display_ctrl.sv
// BCD score register with a digit-serial adder, a vsync-aligned display
// snapshot and raster scheduling of the digit slots.
// Optional: define SCORE_LEADING_ZERO_BLANK_EN to blank leading zeros.
module score_display_ctrl
  import video_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int X0         = 64,
  parameter int Y0         = 32
)(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [8:0]           hpos,
  input  logic [8:0]           vpos,
  input  logic                 vsync,
  score_display_ctrl_if.slave  bus,
  output bcd_t                 digit,
  output logic [2:0]           xofs,
  output logic [2:0]           yofs,
  output logic                 in_window,
  output logic                 overflow
);
  localparam int         IDXW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  // Window bounds held at 10 bits so X0+W near the top of the range cannot wrap.
  localparam logic [9:0] XLO  = 10'(X0);
  localparam logic [9:0] XHI  = 10'(X0 + GLYPH_W * NUM_DIGITS);
  localparam logic [9:0] YLO  = 10'(Y0);
  localparam logic [9:0] YHI  = 10'(Y0 + GLYPH_H);

  add_state_e                 r_state;
  logic [IDXW-1:0]            r_idx;
  bcd_t                       r_carry;
  bcd_t [NUM_DIGITS-1:0]      r_acc, r_shadow;
  logic                       r_ovf, r_pend, r_copy, r_vs_d, r_ready;

  bcd_t       w_sum;
  logic       w_cout, w_last, w_vs_rise, w_copy, w_in;
  logic [8:0] w_dx, w_dy;
  bcd_t       w_dig;

  bcd_digit_add u_add (
    .i_a     (r_acc[r_idx]),
    .i_b     (r_carry),
    .o_sum   (w_sum),
    .o_carry (w_cout)
  );

  assign w_last    = (r_idx == IDXW'(NUM_DIGITS - 1));
  assign w_vs_rise = vsync & ~r_vs_d;
  // Copy either right after an idle vsync or as soon as a deferred one can land.
  assign w_copy    = r_copy | (r_pend & (r_state == S_IDLE));

  assign bus.add_ready = r_ready;
  assign overflow      = r_ovf;

  // Adder FSM, clear handling and snapshot scheduling.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_carry  <= '0;
      r_acc    <= '0;
      r_shadow <= '0;
      r_ovf    <= 1'b0;
      r_pend   <= 1'b0;
      r_copy   <= 1'b0;
      r_vs_d   <= 1'b0;
      r_ready  <= 1'b1;
    end else begin
      r_vs_d <= vsync;
      r_copy <= w_vs_rise & (r_state == S_IDLE);
      if (w_vs_rise && r_state == S_ADD) r_pend <= 1'b1;
      else if (r_pend && r_state == S_IDLE) r_pend <= 1'b0;
      if (w_copy) r_shadow <= r_acc;

      if (bus.clr) begin
        r_acc   <= '0;
        r_ovf   <= 1'b0;
        r_state <= S_IDLE;
        r_idx   <= '0;
        r_carry <= '0;
        r_ready <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: if (bus.add_valid) begin
            r_carry <= bcd_sat(bus.add_value);
            r_idx   <= '0;
            r_state <= S_ADD;
            r_ready <= 1'b0;
          end
          S_ADD: begin
            r_acc[r_idx] <= w_sum;
            r_carry      <= {3'b000, w_cout};
            r_idx        <= r_idx + 1'b1;
            if (!w_cout || w_last) begin
              r_state <= S_IDLE;
              r_ready <= 1'b1;
              if (w_cout) r_ovf <= 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef SCORE_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] r_blank, w_blank;

  // Leading-zero mask of the value about to be snapshotted; LSD never blanks.
  always_comb begin
    logic nz;
    nz      = 1'b0;
    w_blank = '0;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      if (r_acc[k] != 4'd0) nz = 1'b1;
      w_blank[k] = ~nz;
    end
  end

  // Mask travels with the shadow copy so the display never tears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_blank <= ~NUM_DIGITS'(1);
    else if (w_copy) r_blank <= w_blank;
  end
`endif

  assign w_dx = hpos - 9'(X0);
  assign w_dy = vpos - 9'(Y0);
  assign w_in = ({1'b0, hpos} >= XLO) && ({1'b0, hpos} < XHI) &&
                ({1'b0, vpos} >= YLO) && ({1'b0, vpos} < YHI);

  // Slot 0 is leftmost and carries the most significant digit.
  always_comb begin
    w_dig = BLANK_DIGIT;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_dx[8:4] == 5'(i)) begin
        w_dig = r_shadow[NUM_DIGITS-1-i];
`ifdef SCORE_LEADING_ZERO_BLANK_EN
        if (r_blank[NUM_DIGITS-1-i]) w_dig = BLANK_DIGIT;
`endif
      end
    end
  end

  // Registered raster outputs, one pixel behind hpos/vpos.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit     <= BLANK_DIGIT;
      xofs      <= '0;
      yofs      <= '0;
      in_window <= 1'b0;
    end else begin
      in_window <= w_in;
      digit     <= w_in ? w_dig : BLANK_DIGIT;
      xofs      <= w_in ? w_dx[3:1] : 3'd0;
      yofs      <= w_in ? w_dy[3:1] : 3'd0;
    end
  end
endmodule
